// File: rtl/alu_instructions_pkg.sv
// ALU instruction encoding shared by the 32-bit ALU and its issue-side drivers.
// Contents: ALUInstruction enum (4-bit opcode).
package alu_instructions_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_MUL = 4'd6,
    ALU_DIV = 4'd7,
    ALU_MOD = 4'd8,
    ALU_SLL = 4'd9,
    ALU_SRL = 4'd10,
    ALU_SRA = 4'd11
  } ALUInstruction;

endpackage

// File: rtl/alu_wide_sequencer_pkg.sv
// Shared definitions for alu_wide_sequencer.
// Contents: sequencer state enum, ALU word width, op-classification helpers.
package alu_wide_sequencer_pkg;
  import alu_instructions_pkg::*;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Ops whose 64-bit result is exactly two independent or carry-chained 32-bit passes.
  function automatic logic is_wide_chainable(input ALUInstruction inst);
    case (inst)
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND, ALU_OR, ALU_NOT: is_wide_chainable = 1'b1;
      default:                                            is_wide_chainable = 1'b0;
    endcase
  endfunction

  // Ops that consume and produce a carry/borrow across the half boundary.
  function automatic logic is_carry_op(input ALUInstruction inst);
    case (inst)
      ALU_ADD, ALU_SUB: is_carry_op = 1'b1;
      default:          is_carry_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs one 64-bit ALU operation as two passes through the
// shared 32-bit ALU (low half, then high half with chained carry/borrow).
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_valid/o_ready, i_inst, i_a, i_b, i_c   request handshake and operands
//   o_valid/i_ready, o_result, o_c, o_o, o_z, o_n, o_error_unsupported
//                                 result handshake, result and flags
//   o_alu_inst, o_alu_data0, o_alu_data1, o_alu_c   drive to the shared ALU
//   i_alu_result, i_alu_c, i_alu_o                  response from the shared ALU
// All outputs are registered; the ALU drive is loaded one cycle ahead of the
// pass that uses it so it is stable for the whole LOW/HIGH cycle.
module alu_wide_sequencer
  import alu_instructions_pkg::*;
  import alu_wide_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  ALUInstruction        i_inst,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_c,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_c,
  output logic                 o_o,
  output logic                 o_z,
  output logic                 o_n,
  output logic                 o_error_unsupported,
  output ALUInstruction        o_alu_inst,
  output logic [ALU_WIDTH-1:0] o_alu_data0,
  output logic [ALU_WIDTH-1:0] o_alu_data1,
  output logic                 o_alu_c,
  input  logic [ALU_WIDTH-1:0] i_alu_result,
  input  logic                 i_alu_c,
  input  logic                 i_alu_o
);

  seq_state_t           state_r;
  ALUInstruction        inst_r;
  logic [ALU_WIDTH-1:0] a_hi_r;
  logic [ALU_WIDTH-1:0] b_hi_r;
  logic                 carry_op_r;

  // Sequencer FSM with registered handshake, result, flags and ALU drive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r             <= IDLE;
      inst_r              <= ALU_ADD;
      a_hi_r              <= {ALU_WIDTH{1'b0}};
      b_hi_r              <= {ALU_WIDTH{1'b0}};
      carry_op_r          <= 1'b0;
      o_ready             <= 1'b1;
      o_valid             <= 1'b0;
      o_result            <= {WIDTH{1'b0}};
      o_c                 <= 1'b0;
      o_o                 <= 1'b0;
      o_z                 <= 1'b0;
      o_n                 <= 1'b0;
      o_error_unsupported <= 1'b0;
      o_alu_inst          <= ALU_ADD;
      o_alu_data0         <= {ALU_WIDTH{1'b0}};
      o_alu_data1         <= {ALU_WIDTH{1'b0}};
      o_alu_c             <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            inst_r     <= i_inst;
            a_hi_r     <= i_a[WIDTH-1:ALU_WIDTH];
            b_hi_r     <= i_b[WIDTH-1:ALU_WIDTH];
            carry_op_r <= is_carry_op(i_inst);
            o_ready    <= 1'b0;
            o_result   <= {WIDTH{1'b0}};
            o_c        <= 1'b0;
            o_o        <= 1'b0;
            o_z        <= 1'b0;
            o_n        <= 1'b0;
            if (is_wide_chainable(i_inst)) begin
              // Preload the low pass; bitwise ops get a zero carry-in.
              state_r             <= LOW;
              o_error_unsupported <= 1'b0;
              o_alu_inst          <= i_inst;
              o_alu_data0         <= i_a[ALU_WIDTH-1:0];
              o_alu_data1         <= i_b[ALU_WIDTH-1:0];
              o_alu_c             <= is_carry_op(i_inst) ? i_c : 1'b0;
            end else begin
              // Unsupported op never reaches the ALU; report it straight away.
              state_r             <= DONE;
              o_valid             <= 1'b1;
              o_error_unsupported <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        LOW: begin
          o_result[ALU_WIDTH-1:0] <= i_alu_result;
          // Preload the high pass; the chain carry is only meaningful for ADD/SUB.
          o_alu_inst  <= inst_r;
          o_alu_data0 <= a_hi_r;
          o_alu_data1 <= b_hi_r;
          o_alu_c     <= carry_op_r ? i_alu_c : 1'b0;
          state_r     <= HIGH;
        end

        HIGH: begin
          o_result[WIDTH-1:ALU_WIDTH] <= i_alu_result;
          o_c     <= carry_op_r ? i_alu_c : 1'b0;
          o_o     <= carry_op_r ? i_alu_o : 1'b0;
          o_z     <= (i_alu_result == {ALU_WIDTH{1'b0}}) &&
                     (o_result[ALU_WIDTH-1:0] == {ALU_WIDTH{1'b0}});
          o_n     <= i_alu_result[ALU_WIDTH-1];
          // Park the ALU on a harmless ADD of zeros outside the two passes.
          o_alu_inst  <= ALU_ADD;
          o_alu_data0 <= {ALU_WIDTH{1'b0}};
          o_alu_data1 <= {ALU_WIDTH{1'b0}};
          o_alu_c     <= 1'b0;
          o_valid     <= 1'b1;
          state_r     <= DONE;
        end

        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          state_r     <= IDLE;
          o_valid     <= 1'b0;
          o_ready     <= 1'b1;
          o_alu_inst  <= ALU_ADD;
          o_alu_data0 <= {ALU_WIDTH{1'b0}};
          o_alu_data1 <= {ALU_WIDTH{1'b0}};
          o_alu_c     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed self-checking bench for alu_wide_sequencer, with a behavioural
// 32-bit ALU attached to the o_alu_*/i_alu_* ports. SUB reports a borrow on
// o_c; bitwise ops leave o_c/o_o at 1 so any leak into the flags shows up.
module tb_alu_wide_sequencer;
  import alu_instructions_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  ALUInstruction i_inst;
  logic [63:0]   i_a, i_b;
  logic          i_c;
  logic          o_valid;
  logic          i_ready;
  logic [63:0]   o_result;
  logic          o_c, o_o, o_z, o_n, o_error_unsupported;
  ALUInstruction o_alu_inst;
  logic [31:0]   o_alu_data0, o_alu_data1;
  logic          o_alu_c;
  logic [31:0]   i_alu_result;
  logic          i_alu_c, i_alu_o;

  int vectors     = 0;
  int miscompares = 0;
  int mul_seen    = 0;

  always #5 i_clk = ~i_clk;

  alu_wide_sequencer #(.WIDTH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
    .i_a(i_a), .i_b(i_b), .i_c(i_c),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_c(o_c), .o_o(o_o), .o_z(o_z), .o_n(o_n),
    .o_error_unsupported(o_error_unsupported),
    .o_alu_inst(o_alu_inst), .o_alu_data0(o_alu_data0),
    .o_alu_data1(o_alu_data1), .o_alu_c(o_alu_c),
    .i_alu_result(i_alu_result), .i_alu_c(i_alu_c), .i_alu_o(i_alu_o)
  );

  // Behavioural shared ALU.
  always_comb begin
    logic [32:0] t;
    t = 33'd0;
    i_alu_result = 32'd0;
    i_alu_c = 1'b0;
    i_alu_o = 1'b0;
    case (o_alu_inst)
      ALU_ADD: begin
        t = {1'b0, o_alu_data0} + {1'b0, o_alu_data1} + {32'd0, o_alu_c};
        i_alu_result = t[31:0];
        i_alu_c = t[32];
        i_alu_o = (o_alu_data0[31] == o_alu_data1[31]) && (t[31] != o_alu_data0[31]);
      end
      ALU_SUB: begin
        t = {1'b0, o_alu_data0} - {1'b0, o_alu_data1} - {32'd0, o_alu_c};
        i_alu_result = t[31:0];
        i_alu_c = t[32];
        i_alu_o = (o_alu_data0[31] != o_alu_data1[31]) && (t[31] != o_alu_data0[31]);
      end
      ALU_AND: begin i_alu_result = o_alu_data0 & o_alu_data1; i_alu_c = 1'b1; i_alu_o = 1'b1; end
      ALU_OR:  begin i_alu_result = o_alu_data0 | o_alu_data1; i_alu_c = 1'b1; i_alu_o = 1'b1; end
      ALU_XOR: begin i_alu_result = o_alu_data0 ^ o_alu_data1; i_alu_c = 1'b1; i_alu_o = 1'b1; end
      ALU_NOT: begin i_alu_result = ~o_alu_data0;              i_alu_c = 1'b1; i_alu_o = 1'b1; end
      ALU_MUL: i_alu_result = o_alu_data0 * o_alu_data1;
      default: i_alu_result = 32'd0;
    endcase
  end

  // Watch for any unsupported op leaking onto the shared ALU.
  always @(posedge i_clk) begin
    if (o_alu_inst == ALU_MUL || o_alu_inst == ALU_DIV || o_alu_inst == ALU_MOD)
      mul_seen++;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full request/response; inputs are scrambled after accept to prove latching.
  task automatic do_op(input string tag, input ALUInstruction inst,
                       input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [63:0] exp_res, input logic exp_c, input logic exp_o,
                       input logic exp_z, input logic exp_n, input logic exp_err,
                       input int exp_lat, input int hold);
    int lat;
    @(negedge i_clk);
    check({tag, "_ready_idle"}, 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_inst = inst; i_a = a; i_b = b; i_c = c;
    @(negedge i_clk);
    i_valid = 1'b0; i_inst = ALU_MUL; i_a = 64'hDEAD_BEEF_CAFE_F00D; i_b = 64'h0BAD_F00D_1357_9BDF; i_c = ~c;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_flags_czn_o_err"}, {59'd0, o_c, o_z, o_n, o_o, o_error_unsupported},
          {59'd0, exp_c, exp_z, exp_n, exp_o, exp_err});
    check({tag, "_ready_busy"}, 64'(o_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check({tag, "_hold_result"}, o_result, exp_res);
      check({tag, "_hold_valid_ready_z"}, {61'd0, o_valid, o_ready, o_z}, {61'd0, 1'b1, 1'b0, exp_z});
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check({tag, "_after_consume"}, {62'd0, o_valid, o_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_inst = ALU_ADD; i_a = 64'd0; i_b = 64'd0;
    i_c = 1'b0; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("reset_handshake", {62'd0, o_ready, o_valid}, {62'd0, 1'b1, 1'b0});
    check("reset_result", o_result, 64'd0);
    check("reset_flags", {59'd0, o_c, o_o, o_z, o_n, o_error_unsupported}, 64'd0);
    check("reset_alu_drive", {o_alu_inst, o_alu_data0, o_alu_data1, o_alu_c}, 64'd0);
    check("reset_alu_inst_add", 64'(o_alu_inst), 64'(ALU_ADD));
    i_rst = 1'b0;

    //    tag          op       a                       b                       c     result                  c     o     z     n     err   lat hold
    do_op("add_carry", ALU_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1,                 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    do_op("add_wrap",  ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 64'd0,                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    do_op("add_cin",   ALU_ADD, 64'd0,                   64'd0,                 1'b1, 64'd1,                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    do_op("add_ovf",   ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    do_op("sub_borrow",ALU_SUB, 64'h0000_0001_0000_0000, 64'd1,                 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    do_op("sub_neg",   ALU_SUB, 64'd0,                   64'd1,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    do_op("xor_hold",  ALU_XOR, 64'hFFFF_0000_1234_5678, 64'hFFFF_0000_1234_5678, 1'b1, 64'd0,                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 5);
    do_op("not",       ALU_NOT, 64'h0123_4567_89AB_CDEF, 64'd0,                 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    do_op("mul_unsup", ALU_MUL, 64'd3,                   64'd5,                 1'b0, 64'd0,                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);

    // Reset asserted while the high pass is on the ALU.
    @(negedge i_clk);
    i_valid = 1'b1; i_inst = ALU_ADD; i_a = 64'd5; i_b = 64'd6; i_c = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("pre_reset_busy", 64'(o_ready), 64'd0);
    i_rst = 1'b1;
    #1;
    check("async_reset_handshake", {62'd0, o_valid, o_ready}, {62'd0, 1'b0, 1'b1});
    check("async_reset_alu_drive", {o_alu_inst, o_alu_data0, o_alu_data1, o_alu_c}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    do_op("add_after_rst", ALU_ADD, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);

    check("alu_never_mul", 64'(mul_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
Issue-side driver for the 32-bit combinational ALU. It accepts one 64-bit operation over a valid/ready handshake and runs it as two 32-bit ALU passes, low half then high half, chaining the carry/borrow between them. It assembles the 64-bit result and flags and returns them over a valid/ready result handshake. It sits between the execute-stage operand latch and the single shared ALU instance.

Parameters:
WIDTH, 64, operation width; fixed at 2x the ALU word (32); other values unsupported.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  request valid
o_ready  output  1  request accepted when i_valid & o_ready
i_inst  input  ALUInstruction  requested operation
i_a  input  64  operand A
i_b  input  64  operand B
i_c  input  1  carry/borrow in for the low pass
o_valid  output  1  result valid
i_ready  input  1  result consumed when o_valid & i_ready
o_result  output  64  assembled result
o_c  output  1  carry/borrow out of the high pass
o_o  output  1  overflow flag from the high pass
o_z  output  1  1 when all 64 result bits are 0
o_n  output  1  o_result[63]
o_error_unsupported  output  1  op not executable as two chained halves
o_alu_inst  output  ALUInstruction  to ALU i_inst
o_alu_data0  output  32  to ALU i_data0
o_alu_data1  output  32  to ALU i_data1
o_alu_c  output  1  to ALU i_c
i_alu_result  input  32  from ALU o_result
i_alu_c  input  1  from ALU o_c
i_alu_o  input  1  from ALU o_o

Behaviour:
- Reset (async, active-high): state IDLE, o_ready=1, o_valid=0, o_result=0, all flags 0, o_error_unsupported=0, ALU drive = ALU_ADD/0/0/0. Reset mid-operation drops the operation silently.
- Supported ops: ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND, ALU_OR, ALU_NOT. All others are unsupported.
- States:
  - IDLE: o_ready=1. On accept, latch inst, a, b and c. Supported op -> LOW; unsupported -> DONE with error=1 and result and flags 0.
  - LOW: drive inst, a[31:0], b[31:0] and the latched c. Capture i_alu_result into result[31:0]. For ADD/SUB, capture i_alu_c as the chain carry. -> HIGH.
  - HIGH: drive inst, a[63:32], b[63:32] and the chain carry. Capture i_alu_result into result[63:32]. Set o_c = i_alu_c and o_o = i_alu_o. -> DONE.
  - DONE: o_valid=1; outputs held stable. On i_ready -> IDLE, o_valid drops next cycle.
- o_ready=1 only in IDLE. No pipelining; one operation in flight.
- Latency: accept at cycle 0; o_valid is high from cycle 3 (supported) or cycle 1 (unsupported).
- Bitwise ops: the ALU does not assign o_c for these, so i_alu_c and i_alu_o are ignored. Chain carry, o_c and o_o are forced to 0, and o_alu_c is driven 0.
- SUB: borrow semantics follow the ALU; the ALU's o_c bit is the borrow into the high pass.
- o_z and o_n are computed from the registered 64-bit result, not from the ALU z/n outputs.
- ALU drive outside LOW/HIGH: ALU_ADD with zero operands, so the shared ALU never sees DIV/MOD by zero from this block.
- Back-pressure: i_ready low in DONE holds every output indefinitely. i_valid while busy is ignored, and the requester must hold its request.

Decomposition:
- Shared package: state enum (IDLE, LOW, HIGH, DONE); function is_wide_chainable(ALUInstruction); function is_carry_op(ALUInstruction).
- ALUInstruction stays in the existing instructions header.
- No RTL sub-module. The bench instantiates the existing ALU on the o_alu_*/i_alu_* ports.

Test Plan:
- ADD a=0x0000_0000_FFFF_FFFF, b=1, c=0 -> result 0x0000_0001_0000_0000, o_c=0, o_z=0, o_n=0, o_valid exactly 3 cycles after accept.
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, c=0 -> result 0, o_c=1, o_z=1; then ADD a=0, b=0, c=1 -> result 1.
- SUB a=0x0000_0001_0000_0000, b=1, c=0 -> result 0x0000_0000_FFFF_FFFF, o_c=0, o_n=0; SUB a=0, b=1 -> result 0xFFFF_FFFF_FFFF_FFFF, o_n=1.
- XOR a=0xFFFF_0000_1234_5678, b=0xFFFF_0000_1234_5678 -> result 0, o_z=1, o_c=0, o_o=0. Hold i_ready=0 for 5 cycles -> outputs stable and o_ready=0 throughout.
- MUL request -> o_error_unsupported=1, result 0, o_valid at cycle 1. ALU ports never carry ALU_MUL.
- Assert i_rst during HIGH -> o_valid=0 and o_ready=1 immediately (async). A following ADD 2+3 returns 5 with normal latency.
